// File: rtl/pulse_stretcher.sv
// Stretches single-cycle ticks into LED pulses with minimum ON time and OFF gap,
// queueing ticks that arrive mid-pulse. Optional RETRIGGER_EN: ticks in ON extend the pulse.
//
// state   | meaning
// ST_IDLE | LED off, nothing queued, waiting for a tick
// ST_ON   | LED on, timing OnCycles
// ST_OFF  | LED off, timing the forced OffCycles gap
module pulse_stretcher #(
    parameter int ClkFreq    = 100_000_000,
    parameter int OnTimeUs   = 100_000,
    parameter int OffTimeUs  = 50_000,
    parameter int MaxPending = 7,
    localparam int PendW     = $clog2(MaxPending + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    output logic             led_o,
    output logic             busy_o,
    output logic [PendW-1:0] pending_o,
    output logic             overflow_o
);

    // 64-bit product avoids overflow for large clock/time combinations
    localparam longint OnCyclesL  = longint'(ClkFreq) * longint'(OnTimeUs) / 64'd1_000_000;
    localparam longint OffCyclesL = longint'(ClkFreq) * longint'(OffTimeUs) / 64'd1_000_000;
    localparam int OnCycles  = int'(OnCyclesL);
    localparam int OffCycles = int'(OffCyclesL);
    localparam int CntMax    = (OnCycles > OffCycles) ? OnCycles : OffCycles;
    localparam int CntW      = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]  ON_LAST  = CntW'(OnCycles - 1);
    localparam logic [CntW-1:0]  OFF_LAST = CntW'(OffCycles - 1);
    localparam logic [PendW-1:0] PEND_MAX = PendW'(MaxPending);

    if (OnCycles < 1 || OffCycles < 1 || MaxPending < 1) begin : g_param_check
        $error("pulse_stretcher: OnCycles, OffCycles and MaxPending must all be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic             pend_inc, pend_dec;
    logic             ovf_d, led_d, busy_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            led_o      <= 1'b0;
            busy_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            led_o      <= led_d;
            busy_o     <= busy_d;
            overflow_o <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_inc = 1'b0;
        pend_dec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q != '0) begin
                    state_d  = ST_ON;
                    cnt_d    = '0;
                    pend_dec = 1'b1;
                    pend_inc = tick_i;
                end else if (tick_i) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
`ifdef RETRIGGER_EN
                if (tick_i) begin
                    cnt_d = '0;
                end else if (cnt_q == ON_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                pend_inc = tick_i;
                if (cnt_q == ON_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_OFF: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d = '0;
                    if (pend_q != '0) begin
                        state_d  = ST_ON;
                        pend_dec = 1'b1;
                        pend_inc = tick_i;
                    end else if (tick_i) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    pend_inc = tick_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A simultaneous replay and new tick leave the queue depth untouched
    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (pend_inc && !pend_dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (pend_dec && !pend_inc) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_comb begin
        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    assign pending_o = pend_q;

endmodule
